// File: rtl/imm_pipe_if.sv
// Valid/ready bundle between the format decoder, imm_pipe and the ID/EX register.
// The slave modport is the pipe's view; the master modport is the surrounding pipeline's view.
interface imm_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             i_valid;
    logic             o_ready;
    logic [31:0]      i_inst;
    logic [6:0]       i_format;
    logic [TAG_W-1:0] i_tag;
    logic             o_valid;
    logic             i_ready;
    logic [XLEN-1:0]  o_immediate;
    logic [TAG_W-1:0] o_tag;
    logic             o_fmt_err;

    modport slave (
        input  i_valid, i_inst, i_format, i_tag, i_ready,
        output o_ready, o_valid, o_immediate, o_tag, o_fmt_err
    );

    modport master (
        output i_valid, i_inst, i_format, i_tag, i_ready,
        input  o_ready, o_valid, o_immediate, o_tag, o_fmt_err
    );
endinterface

// File: rtl/imm_pipe.sv
// Pipelined immediate generator: decodes the sign-extended immediate for a one-hot format
// and presents it, with its tag, through a main register backed by a one-entry skid register.
module imm_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_flush,
    imm_pipe_if.slave bus
);

    if ((XLEN != 32) && (XLEN != 64)) begin : g_xlen_check
        $error("imm_pipe: XLEN must be 32 or 64");
    end

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // Returns {fmt_err, immediate}; anything other than exactly one format bit is an error.
    function automatic logic [XLEN:0] decode_imm(input logic [31:0] inst, input logic [6:0] fmt);
        logic s;
        s = inst[31];
        case (fmt)
            7'b0000001: decode_imm = {1'b0, {XLEN{1'b0}}};
            7'b0000010: decode_imm = {1'b0, {(XLEN-11){s}}, inst[30:20]};
            7'b0000100: decode_imm = {1'b0, {(XLEN-11){s}}, inst[30:25], inst[11:7]};
            7'b0001000: decode_imm = {1'b0, {(XLEN-12){s}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            7'b0010000: decode_imm = {1'b0, {(XLEN-31){s}}, inst[30:12], 12'h000};
            7'b0100000: decode_imm = {1'b0, {(XLEN-20){s}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            7'b1000000: decode_imm = {1'b0, {(XLEN-5){1'b0}}, inst[19:15]};
            default:    decode_imm = {1'b1, {XLEN{1'b0}}};
        endcase
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_acc;
    logic             w_pop;
    logic             w_valid;
    logic             w_ready;
    logic             w_ld_main_in;
    logic             w_ld_main_skid;
    logic             w_ld_skid;
    logic [XLEN:0]    w_dec;

    logic [XLEN-1:0]  r_main_imm;
    logic [TAG_W-1:0] r_main_tag;
    logic             r_main_err;
    logic [XLEN-1:0]  r_skid_imm;
    logic [TAG_W-1:0] r_skid_tag;
    logic             r_skid_err;

    // Handshake qualifiers are derived from the registered state only, so o_ready never
    // depends combinationally on i_ready.
    assign w_acc = bus.i_valid & (r_state != ST_TWO);
    assign w_pop = (r_state != ST_EMPTY) & bus.i_ready;
    assign w_dec = decode_imm(bus.i_inst, bus.i_format);

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; flush overrides any accept or pop.
    always_comb begin
        w_state_nxt = r_state;
        if (i_flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: w_state_nxt = w_acc ? ST_ONE : ST_EMPTY;
                ST_ONE: begin
                    if (w_acc && !w_pop) begin
                        w_state_nxt = ST_TWO;
                    end else if (!w_acc && w_pop) begin
                        w_state_nxt = ST_EMPTY;
                    end else begin
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_TWO:   w_state_nxt = w_pop ? ST_ONE : ST_TWO;
                default:  w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Output decode and data-register load enables.
    always_comb begin
        w_valid        = 1'b0;
        w_ready        = 1'b1;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                w_valid      = 1'b0;
                w_ready      = 1'b1;
                w_ld_main_in = w_acc & ~i_flush;
            end
            ST_ONE: begin
                w_valid      = 1'b1;
                w_ready      = 1'b1;
                w_ld_main_in = w_acc & w_pop & ~i_flush;
                w_ld_skid    = w_acc & ~w_pop & ~i_flush;
            end
            ST_TWO: begin
                w_valid        = 1'b1;
                w_ready        = 1'b0;
                w_ld_main_skid = w_pop & ~i_flush;
            end
            default: begin
                w_valid = 1'b0;
                w_ready = 1'b1;
            end
        endcase
    end

    // Main and skid data registers; they change only when loaded.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_main_imm <= {XLEN{1'b0}};
            r_main_tag <= {TAG_W{1'b0}};
            r_main_err <= 1'b0;
            r_skid_imm <= {XLEN{1'b0}};
            r_skid_tag <= {TAG_W{1'b0}};
            r_skid_err <= 1'b0;
        end else begin
            if (w_ld_main_in) begin
                r_main_imm <= w_dec[XLEN-1:0];
                r_main_tag <= bus.i_tag;
                r_main_err <= w_dec[XLEN];
            end else if (w_ld_main_skid) begin
                r_main_imm <= r_skid_imm;
                r_main_tag <= r_skid_tag;
                r_main_err <= r_skid_err;
            end
            if (w_ld_skid) begin
                r_skid_imm <= w_dec[XLEN-1:0];
                r_skid_tag <= bus.i_tag;
                r_skid_err <= w_dec[XLEN];
            end
        end
    end

    assign bus.o_valid     = w_valid;
    assign bus.o_ready     = w_ready;
    assign bus.o_immediate = r_main_imm;
    assign bus.o_tag       = r_main_tag;
    assign bus.o_fmt_err   = r_main_err;

endmodule

// File: tb/tb_imm_pipe.sv
// Scoreboard bench for imm_pipe: XLEN=32 and XLEN=64 instances driven in lockstep,
// expected results queued on accept and compared on each output transfer.
module tb_imm_pipe;

    typedef struct packed {
        logic [63:0] imm;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] inst;
        logic [6:0]  fmt;
        logic [63:0] imm;
        logic        err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    always #5 clk = ~clk;

    imm_pipe_if #(.XLEN(32), .TAG_W(5)) if32 ();
    imm_pipe_if #(.XLEN(64), .TAG_W(5)) if64 ();

    imm_pipe #(.XLEN(32), .TAG_W(5)) u_dut32 (.i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .bus(if32));
    imm_pipe #(.XLEN(64), .TAG_W(5)) u_dut64 (.i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .bus(if64));

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q32[$];
    exp_t q64[$];
    exp_t cur_exp;
    logic acc_seen;
    vec_t vecs[10];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference decode written from the field layout using signed casts.
    function automatic exp_t model(input logic [31:0] inst, input logic [6:0] fmt, input logic [4:0] tag);
        exp_t e;
        logic signed [63:0] v;
        e.tag = tag;
        e.err = 1'b0;
        case (fmt)
            7'b0000001: v = 64'sd0;
            7'b0000010: v = 64'($signed(inst[31:20]));
            7'b0000100: v = 64'($signed({inst[31:25], inst[11:7]}));
            7'b0001000: v = 64'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
            7'b0010000: v = 64'($signed({inst[31:12], 12'h000}));
            7'b0100000: v = 64'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
            7'b1000000: v = 64'($signed({59'd0, inst[19:15]}));
            default: begin
                v     = 64'sd0;
                e.err = 1'b1;
            end
        endcase
        e.imm = v;
        return e;
    endfunction

    task automatic drive(input logic [31:0] inst, input logic [6:0] fmt, input logic [4:0] tag);
        if32.i_valid = 1'b1; if32.i_inst = inst; if32.i_format = fmt; if32.i_tag = tag;
        if64.i_valid = 1'b1; if64.i_inst = inst; if64.i_format = fmt; if64.i_tag = tag;
        cur_exp = model(inst, fmt, tag);
    endtask

    task automatic drive_lit(input vec_t v, input logic [4:0] tag);
        drive(v.inst, v.fmt, tag);
        cur_exp.imm = v.imm;
        cur_exp.err = v.err;
    endtask

    task automatic idle();
        if32.i_valid = 1'b0;
        if64.i_valid = 1'b0;
    endtask

    task automatic set_ready(input logic r);
        if32.i_ready = r;
        if64.i_ready = r;
    endtask

    // One clock: scoreboard at the negedge, then return #1 after the next posedge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        acc_seen = 1'b0;
        if (!rst_n || flush) begin
            q32.delete();
            q64.delete();
        end else begin
            if (if32.o_valid && if32.i_ready) begin
                if (q32.size() == 0) begin
                    check_val("extra32", 64'd1, 64'd0);
                end else begin
                    e = q32.pop_front();
                    check_val("imm32", {32'd0, if32.o_immediate}, {32'd0, e.imm[31:0]});
                    check_val("tag32", {59'd0, if32.o_tag}, {59'd0, e.tag});
                    check_val("err32", {63'd0, if32.o_fmt_err}, {63'd0, e.err});
                end
            end
            if (if64.o_valid && if64.i_ready) begin
                if (q64.size() == 0) begin
                    check_val("extra64", 64'd1, 64'd0);
                end else begin
                    e = q64.pop_front();
                    check_val("imm64", if64.o_immediate, e.imm);
                    check_val("tag64", {59'd0, if64.o_tag}, {59'd0, e.tag});
                    check_val("err64", {63'd0, if64.o_fmt_err}, {63'd0, e.err});
                end
            end
            if (if32.i_valid && if32.o_ready) begin
                q32.push_back(cur_exp);
                acc_seen = 1'b1;
            end
            if (if64.i_valid && if64.o_ready) begin
                q64.push_back(cur_exp);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_v32"},   {63'd0, if32.o_valid},     64'd0);
        check_val({tag, "_r32"},   {63'd0, if32.o_ready},     64'd1);
        check_val({tag, "_imm32"}, {32'd0, if32.o_immediate}, 64'd0);
        check_val({tag, "_tag32"}, {59'd0, if32.o_tag},       64'd0);
        check_val({tag, "_err32"}, {63'd0, if32.o_fmt_err},   64'd0);
        check_val({tag, "_v64"},   {63'd0, if64.o_valid},     64'd0);
        check_val({tag, "_r64"},   {63'd0, if64.o_ready},     64'd1);
        check_val({tag, "_imm64"}, if64.o_immediate,          64'd0);
        check_val({tag, "_tag64"}, {59'd0, if64.o_tag},       64'd0);
        check_val({tag, "_err64"}, {63'd0, if64.o_fmt_err},   64'd0);
    endtask

    task automatic fill_two(input logic [4:0] tag0);
        set_ready(1'b0);
        drive(32'h00700093, 7'b0000010, tag0);
        step();
        drive(32'hFF810113, 7'b0000010, tag0 + 5'd1);
        step();
        check_val("two_ready32", {63'd0, if32.o_ready}, 64'd0);
        check_val("two_ready64", {63'd0, if64.o_ready}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] items[4];
        logic [6:0]  f;
        int          idx;
        int          r;

        vecs[0] = '{32'hFE000EE3, 7'b0001000, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
        vecs[1] = '{32'hFE112E23, 7'b0000100, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
        vecs[2] = '{32'hFF5FF06F, 7'b0100000, 64'hFFFF_FFFF_FFFF_FFF4, 1'b0};
        vecs[3] = '{32'h800002B7, 7'b0010000, 64'hFFFF_FFFF_8000_0000, 1'b0};
        vecs[4] = '{32'h3400F073, 7'b1000000, 64'h0000_0000_0000_0001, 1'b0};
        vecs[5] = '{32'h3400F073, 7'b0000110, 64'h0000_0000_0000_0000, 1'b1};
        vecs[6] = '{32'h00B50533, 7'b0000001, 64'h0000_0000_0000_0000, 1'b0};
        vecs[7] = '{32'h12345678, 7'b0000000, 64'h0000_0000_0000_0000, 1'b1};
        vecs[8] = '{32'h00500093, 7'b0000010, 64'h0000_0000_0000_0005, 1'b0};
        vecs[9] = '{32'h12345037, 7'b0010000, 64'h0000_0000_1234_5000, 1'b0};

        rst_n = 1'b0;
        flush = 1'b0;
        cur_exp = '0;
        acc_seen = 1'b0;
        drive(32'd0, 7'd0, 5'd0);
        idle();
        set_ready(1'b1);
        repeat (2) step();
        check_reset("rst");
        rst_n = 1'b1;

        // addi x1,x0,-1 appears one cycle after acceptance
        vecs[0].inst = vecs[0].inst;
        drive_lit('{32'hFFF00093, 7'b0000010, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0}, 5'd1);
        step();
        idle();
        check_val("lat_v32",   {63'd0, if32.o_valid},     64'd1);
        check_val("lat_imm32", {32'd0, if32.o_immediate}, 64'h0000_0000_FFFF_FFFF);
        check_val("lat_tag32", {59'd0, if32.o_tag},       64'd1);
        step();

        // Directed decode vectors, one accept per cycle
        for (int i = 0; i < 10; i++) begin
            drive_lit(vecs[i], 5'(i + 2));
            step();
            check_val("acc_vec", {63'd0, acc_seen}, 64'd1);
        end
        idle();
        repeat (2) step();
        check_val("vec_drained", {63'd0, if32.o_valid}, 64'd0);

        // Back-pressure: two accepted, outputs hold, then four emerge back to back
        items[0] = 32'h00100093; items[1] = 32'hFFF10113;
        items[2] = 32'h7FF18193; items[3] = 32'h80020213;
        set_ready(1'b0);
        drive(items[0], 7'b0000010, 5'd16);
        step();
        drive(items[1], 7'b0000010, 5'd17);
        step();
        drive(items[2], 7'b0000010, 5'd18);
        check_val("bp_ready32", {63'd0, if32.o_ready}, 64'd0);
        check_val("bp_ready64", {63'd0, if64.o_ready}, 64'd0);
        repeat (3) begin
            step();
            check_val("bp_noacc", {63'd0, acc_seen}, 64'd0);
            check_val("bp_valid", {63'd0, if32.o_valid}, 64'd1);
            check_val("bp_hold32", {32'd0, if32.o_immediate}, {32'd0, q32[0].imm[31:0]});
            check_val("bp_hold64", if64.o_immediate, q64[0].imm);
        end
        set_ready(1'b1);
        idx = 2;
        for (int c = 0; c < 4; c++) begin
            check_val("stream_v32", {63'd0, if32.o_valid}, 64'd1);
            check_val("stream_v64", {63'd0, if64.o_valid}, 64'd1);
            step();
            if (acc_seen && idx < 4) begin
                idx++;
                if (idx < 4) drive(items[idx], 7'b0000010, 5'(16 + idx));
                else idle();
            end
        end
        check_val("stream_done", {63'd0, if32.o_valid}, 64'd0);
        check_val("stream_q32", 64'(q32.size()), 64'd0);
        check_val("stream_q64", 64'(q64.size()), 64'd0);

        // Flush while full, with a concurrent offer that must be lost
        fill_two(5'd20);
        drive(32'h00A00093, 7'b0000010, 5'd22);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        check_val("fl_v32", {63'd0, if32.o_valid}, 64'd0);
        check_val("fl_r32", {63'd0, if32.o_ready}, 64'd1);
        check_val("fl_v64", {63'd0, if64.o_valid}, 64'd0);
        check_val("fl_r64", {63'd0, if64.o_ready}, 64'd1);
        set_ready(1'b1);
        repeat (2) step();
        check_val("fl_lost", {63'd0, if32.o_valid}, 64'd0);

        // Reset while full, with flush also asserted
        fill_two(5'd24);
        flush = 1'b1;
        rst_n = 1'b0;
        drive(32'h00B00093, 7'b0000010, 5'd26);
        step();
        check_reset("rst_mid");
        rst_n = 1'b1;
        flush = 1'b0;
        idle();
        set_ready(1'b1);
        step();

        // Random traffic with occasional flushes and illegal formats
        for (int c = 0; c < 400; c++) begin
            r = $urandom_range(0, 7);
            f = 7'd1;
            f = f << r;
            if (r == 7) f = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0) drive($urandom, f, 5'($urandom_range(0, 31)));
            else idle();
            set_ready($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 49) == 0);
            step();
        end
        flush = 1'b0;
        idle();
        set_ready(1'b1);
        for (int c = 0; c < 10; c++) begin
            if (q32.size() != 0 || q64.size() != 0 || if32.o_valid || if64.o_valid) step();
        end
        check_val("drain_q32", 64'(q32.size()), 64'd0);
        check_val("drain_q64", 64'(q64.size()), 64'd0);
        check_val("drain_v32", {63'd0, if32.o_valid}, 64'd0);
        check_val("drain_v64", {63'd0, if64.o_valid}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
